// File: rtl/alu_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_if
// Description : Handshake bundle for alu_iter_unit.
//               Request side : in_valid, in_ready, op, a, b
//               Response side: out_valid, out_ready, result, result_hi,
//                              flag_z, flag_n, flag_c, flag_v, err
//               master = requester/consumer, slave = the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi,
               flag_z, flag_n, flag_c, flag_v, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi,
               flag_z, flag_n, flag_c, flag_v, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_unit
// Description : Multi-cycle ALU. ADD/SUB/AND/OR/MOV and the reserved op finish
//               in one cycle; MUL (shift-add) and MOD (restoring division)
//               iterate one bit per cycle for WIDTH cycles.
// Ports       : clk, rst (sync, active-high)
//               bus (alu_iter_if.slave): in_valid/in_ready/op/a/b request,
//               out_valid/out_ready/result/result_hi/flags/err response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_iter_if.slave  bus
);
    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
    localparam logic [2:0] c_op_mov = 3'b100;
    localparam logic [2:0] c_op_mul = 3'b101;
    localparam logic [2:0] c_op_mod = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_MOD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;   // MUL: running upper product; MOD: partial remainder
    logic [WIDTH-1:0] r_lo;    // MUL: multiplier shifting into product low half; MOD: dividend shifting into quotient
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_flag_z;
    logic             r_flag_n;
    logic             r_flag_c;
    logic             r_flag_v;
    logic             r_err;

    logic             w_load_out;
    logic [WIDTH-1:0] w_fin_res;
    logic [WIDTH-1:0] w_fin_hi;
    logic             w_fin_c;
    logic             w_fin_v;
    logic             w_fin_err;
    logic [WIDTH:0]   w_add_sum;
    logic [WIDTH-1:0] w_sub_diff;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_mod_shift;
    logic             w_mod_fits;
    logic [WIDTH-1:0] w_mod_diff;
    logic [WIDTH-1:0] w_mod_rem;
    logic [WIDTH-1:0] w_mod_q;
    logic             w_last_iter;

    // Single-cycle arithmetic works straight off the request bus at accept.
    assign w_add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub_diff = bus.a - bus.b;

    // One shift-add step: add a when the current multiplier bit is set,
    // then shift the {acc,lo} pair right by one.
    assign w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH + 1){1'b0}});
    assign w_mul_acc = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // One restoring-division step. The remainder after a successful subtract
    // is below b, so WIDTH bits hold it. With b==0 every step "fits", which
    // naturally leaves remainder=a and quotient=all-ones.
    assign w_mod_shift = {r_acc, r_lo[WIDTH-1]};
    assign w_mod_fits  = (w_mod_shift >= {1'b0, r_b});
    assign w_mod_diff  = w_mod_shift[WIDTH-1:0] - r_b;
    assign w_mod_rem   = w_mod_fits ? w_mod_diff : w_mod_shift[WIDTH-1:0];
    assign w_mod_q     = {r_lo[WIDTH-2:0], w_mod_fits};

    assign w_last_iter = (r_cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and final-result selection
    always_comb begin
        w_next_state = r_state;
        w_load_out   = 1'b0;
        w_fin_res    = '0;
        w_fin_hi     = '0;
        w_fin_c      = 1'b0;
        w_fin_v      = 1'b0;
        w_fin_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == c_op_mul) begin
                        w_next_state = S_MUL;
                    end else if (bus.op == c_op_mod) begin
                        w_next_state = S_MOD;
                    end else begin
                        w_next_state = S_DONE;
                        w_load_out   = 1'b1;
                    end
                end
                case (bus.op)
                    c_op_add: begin
                        w_fin_res = w_add_sum[WIDTH-1:0];
                        w_fin_c   = w_add_sum[WIDTH];
                        w_fin_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                    (w_add_sum[WIDTH-1] != bus.a[WIDTH-1]);
                    end
                    c_op_sub: begin
                        w_fin_res = w_sub_diff;
                        w_fin_c   = (bus.a < bus.b);
                        w_fin_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                    (w_sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
                    end
                    c_op_and: w_fin_res = bus.a & bus.b;
                    c_op_or:  w_fin_res = bus.a | bus.b;
                    c_op_mov: w_fin_res = bus.b;
                    c_op_mul, c_op_mod: w_fin_res = '0;
                    default:  w_fin_err = 1'b1;
                endcase
            end
            S_MUL: begin
                w_fin_res = w_mul_lo;
                w_fin_hi  = w_mul_acc;
                w_fin_c   = |w_mul_acc;
                w_fin_v   = |w_mul_acc;
                if (w_last_iter) begin
                    w_next_state = S_DONE;
                    w_load_out   = 1'b1;
                end
            end
            S_MOD: begin
                w_fin_res = w_mod_rem;
                w_fin_hi  = w_mod_q;
                w_fin_err = (r_b == '0);
                if (w_last_iter) begin
                    w_next_state = S_DONE;
                    w_load_out   = 1'b1;
                end
            end
            default: begin
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
        endcase
    end

    // Operand latch, iteration datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_cnt <= CNT_W'(WIDTH);
                        r_acc <= '0;
                        r_lo  <= (bus.op == c_op_mul) ? bus.b : bus.a;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_MOD: begin
                    r_acc <= w_mod_rem;
                    r_lo  <= w_mod_q;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
            // Outputs change only when DONE is entered, so they hold through backpressure.
            if (w_load_out) begin
                r_result    <= w_fin_res;
                r_result_hi <= w_fin_hi;
                r_flag_z    <= (w_fin_res == '0);
                r_flag_n    <= w_fin_res[WIDTH-1];
                r_flag_c    <= w_fin_c;
                r_flag_v    <= w_fin_v;
                r_err       <= w_fin_err;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_n    = r_flag_n;
    assign bus.flag_c    = r_flag_c;
    assign bus.flag_v    = r_flag_v;
    assign bus.err       = r_err;
endmodule
`default_nettype wire
